game_round_controller: RTL and testbench



---
 rtl/game_round_controller.sv | 130 +++++++++++++
 tb/tb_game_round_controller.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/game_round_controller.sv
// Session sequencer above the game master: gates the master's reset, tallies
// rounds into score/lives/level, and drives the target speed and game-over flag.
module game_round_controller #(
  parameter int unsigned LIVES_INIT     = 3,
  parameter int unsigned HITS_PER_LEVEL = 3,
  parameter int unsigned N_LEVELS       = 4,
  parameter int unsigned BASE_SPEED     = 1,
  parameter int unsigned SPEED_STEP     = 2,
  parameter int unsigned W_SCORE        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key,
  input  logic               round_done,
  input  logic               round_won,
  input  logic               timer_running,
  output logic               master_reset,
  output logic [3:0]         target_speed,
  output logic [1:0]         level,
  output logic [W_SCORE-1:0] score,
  output logic [2:0]         lives,
  output logic               game_over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_TALLY,
    S_WAIT_TIMER,
    S_OVER
  } state_t;

  localparam logic [3:0] HIT_LAST  = 4'(HITS_PER_LEVEL - 1);
  localparam logic [1:0] LEVEL_MAX = 2'(N_LEVELS - 1);

  state_t             state, state_nxt;
  logic [W_SCORE-1:0] score_nxt;
  logic [2:0]         lives_nxt;
  logic [1:0]         level_nxt;
  logic [3:0]         hit_cnt, hit_cnt_nxt;
  logic               key_prev;
  logic               seen_timer, seen_timer_nxt;
  logic               won, won_nxt;
  logic               key_rise;

  assign key_rise     = key & ~key_prev;
  assign target_speed = 4'(BASE_SPEED) + 4'(4'(level) * 4'(SPEED_STEP));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      score      <= '0;
      lives      <= 3'(LIVES_INIT);
      level      <= '0;
      hit_cnt    <= '0;
      key_prev   <= 1'b1;
      seen_timer <= 1'b0;
      won        <= 1'b0;
    end else begin
      state      <= state_nxt;
      score      <= score_nxt;
      lives      <= lives_nxt;
      level      <= level_nxt;
      hit_cnt    <= hit_cnt_nxt;
      key_prev   <= key;
      seen_timer <= seen_timer_nxt;
      won        <= won_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    score_nxt      = score;
    lives_nxt      = lives;
    level_nxt      = level;
    hit_cnt_nxt    = hit_cnt;
    seen_timer_nxt = seen_timer;
    won_nxt        = won;
    master_reset   = 1'b0;
    game_over      = 1'b0;

    case (state)
      S_IDLE: begin
        master_reset = 1'b1;
        if (key_rise) begin
          score_nxt   = '0;
          lives_nxt   = 3'(LIVES_INIT);
          level_nxt   = '0;
          hit_cnt_nxt = '0;
          state_nxt   = S_PLAY;
        end
      end
      S_PLAY: begin
        if (round_done) begin
          won_nxt   = round_won;
          state_nxt = S_TALLY;
        end
      end
      S_TALLY: begin
        if (won) begin
          if (score != '1) score_nxt = score + W_SCORE'(1);
          if (hit_cnt == HIT_LAST) begin
            hit_cnt_nxt = '0;
            if (level != LEVEL_MAX) level_nxt = level + 2'd1;
          end else begin
            hit_cnt_nxt = hit_cnt + 4'd1;
          end
        end else begin
          if (lives != 3'd0) lives_nxt = lives - 3'd1;
          hit_cnt_nxt = '0;
        end
        seen_timer_nxt = 1'b0;
        state_nxt      = S_WAIT_TIMER;
      end
      S_WAIT_TIMER: begin
        // The master finishes END->START on its own; leave only once the timer has come and gone.
        if (timer_running) seen_timer_nxt = 1'b1;
        if (seen_timer && !timer_running)
          state_nxt = (lives == 3'd0) ? S_OVER : S_PLAY;
      end
      S_OVER: begin
        master_reset = 1'b1;
        game_over    = 1'b1;
        if (key_rise) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_game_round_controller.sv
// Directed bench for game_round_controller: a default instance and a W_SCORE=2
// instance share all inputs so score saturation is checked alongside the session.
module tb_game_round_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       key;
  logic       round_done;
  logic       round_won;
  logic       timer_running;

  logic       master_reset, game_over;
  logic [3:0] target_speed;
  logic [1:0] level;
  logic [7:0] score;
  logic [2:0] lives;

  logic       master_reset_s2, game_over_s2;
  logic [3:0] target_speed_s2;
  logic [1:0] level_s2;
  logic [1:0] score_s2;
  logic [2:0] lives_s2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  game_round_controller dut (
    .clk(clk), .reset(reset), .key(key), .round_done(round_done),
    .round_won(round_won), .timer_running(timer_running),
    .master_reset(master_reset), .target_speed(target_speed), .level(level),
    .score(score), .lives(lives), .game_over(game_over)
  );

  game_round_controller #(.W_SCORE(2)) dut_s2 (
    .clk(clk), .reset(reset), .key(key), .round_done(round_done),
    .round_won(round_won), .timer_running(timer_running),
    .master_reset(master_reset_s2), .target_speed(target_speed_s2), .level(level_s2),
    .score(score_s2), .lives(lives_s2), .game_over(game_over_s2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press_key();
    key = 1'b0;
    tick();
    key = 1'b1;
    tick();
  endtask

  task automatic check_outputs(input string tag, input int exp_score, input int exp_score2,
                               input int exp_lives, input int exp_level, input int exp_speed);
    check({tag, ".score"},  32'(score),        32'(exp_score));
    check({tag, ".score2"}, 32'(score_s2),     32'(exp_score2));
    check({tag, ".lives"},  32'(lives),        32'(exp_lives));
    check({tag, ".level"},  32'(level),        32'(exp_level));
    check({tag, ".speed"},  32'(target_speed), 32'(exp_speed));
  endtask

  // One round: pulse round_done, run the timer for 5 cycles starting in the TALLY cycle.
  task automatic play_round(input string tag, input bit won, input int exp_score,
                            input int exp_score2, input int exp_lives, input int exp_level,
                            input int exp_speed, input bit exp_over);
    round_done = 1'b1;
    round_won  = won;
    tick();
    round_done    = 1'b0;
    round_won     = 1'b0;
    timer_running = 1'b1;
    tick();
    check_outputs(tag, exp_score, exp_score2, exp_lives, exp_level, exp_speed);
    check({tag, ".mr_wait"}, 32'(master_reset), 32'd0);
    repeat (4) tick();
    check({tag, ".mr_timer"}, 32'(master_reset), 32'd0);
    timer_running = 1'b0;
    tick();
    check({tag, ".over"},     32'(game_over),    32'(exp_over));
    check({tag, ".mr_after"}, 32'(master_reset), 32'(exp_over));
  endtask

  initial begin
    reset         = 1'b1;
    key           = 1'b1;
    round_done    = 1'b0;
    round_won     = 1'b0;
    timer_running = 1'b0;

    // 1. Reset with key held; no session may start from the held key.
    repeat (3) tick();
    check("rst.mr", 32'(master_reset), 32'd1);
    check("rst.over", 32'(game_over), 32'd0);
    check_outputs("rst", 0, 0, 3, 0, 1);
    reset = 1'b0;
    repeat (10) tick();
    check("held_key.mr", 32'(master_reset), 32'd1);

    key = 1'b0;
    tick();
    key = 1'b1;
    check("pre_rise.mr", 32'(master_reset), 32'd1);
    tick();
    check("start.mr", 32'(master_reset), 32'd0);
    check_outputs("start", 0, 0, 3, 0, 1);

    // 2-4. Wins, a loss clearing the streak, and level climb to saturation.
    play_round("r1",  1'b1, 1,  1, 3, 0, 1, 1'b0);
    play_round("r2",  1'b1, 2,  2, 3, 0, 1, 1'b0);
    play_round("r3",  1'b0, 2,  2, 2, 0, 1, 1'b0);
    play_round("r4",  1'b1, 3,  3, 2, 0, 1, 1'b0);
    play_round("r5",  1'b1, 4,  3, 2, 0, 1, 1'b0);
    play_round("r6",  1'b1, 5,  3, 2, 1, 3, 1'b0);
    play_round("r7",  1'b1, 6,  3, 2, 1, 3, 1'b0);
    play_round("r8",  1'b1, 7,  3, 2, 1, 3, 1'b0);
    play_round("r9",  1'b1, 8,  3, 2, 2, 5, 1'b0);
    play_round("r10", 1'b1, 9,  3, 2, 2, 5, 1'b0);
    play_round("r11", 1'b1, 10, 3, 2, 2, 5, 1'b0);
    play_round("r12", 1'b1, 11, 3, 2, 3, 7, 1'b0);
    play_round("r13", 1'b1, 12, 3, 2, 3, 7, 1'b0);
    play_round("r14", 1'b1, 13, 3, 2, 3, 7, 1'b0);
    play_round("r15", 1'b1, 14, 3, 2, 3, 7, 1'b0);
    play_round("r16", 1'b0, 14, 3, 1, 3, 7, 1'b0);
    play_round("r17", 1'b0, 14, 3, 0, 3, 7, 1'b1);

    // round_done in OVER is ignored; values held for display.
    round_done = 1'b1;
    round_won  = 1'b0;
    tick();
    round_done = 1'b0;
    repeat (3) tick();
    check("over_hold.over", 32'(game_over), 32'd1);
    check_outputs("over_hold", 14, 3, 0, 3, 7);

    // 5. First key_rise -> IDLE with counters untouched, second -> new session.
    press_key();
    check("idle.mr", 32'(master_reset), 32'd1);
    check("idle.over", 32'(game_over), 32'd0);
    check_outputs("idle", 14, 3, 0, 3, 7);
    press_key();
    check("restart.mr", 32'(master_reset), 32'd0);
    check_outputs("restart", 0, 0, 3, 0, 1);

    // Key in PLAY is left to the master.
    press_key();
    check("play_key.mr", 32'(master_reset), 32'd0);
    check("play_key.over", 32'(game_over), 32'd0);

    play_round("l1", 1'b0, 0, 0, 2, 0, 1, 1'b0);
    play_round("l2", 1'b0, 0, 0, 1, 0, 1, 1'b0);
    play_round("l3", 1'b0, 0, 0, 0, 0, 1, 1'b1);

    // 6. Async reset in the middle of WAIT_TIMER.
    press_key();
    press_key();
    play_round("s6", 1'b1, 1, 1, 3, 0, 1, 1'b0);
    round_done = 1'b1;
    round_won  = 1'b1;
    tick();
    round_done    = 1'b0;
    timer_running = 1'b1;
    tick();
    tick();
    check_outputs("s6_wait", 2, 2, 3, 0, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async.mr", 32'(master_reset), 32'd1);
    check("async.over", 32'(game_over), 32'd0);
    check_outputs("async", 0, 0, 3, 0, 1);
    timer_running = 1'b0;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("post_rst.mr", 32'(master_reset), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
